change_dispenser: RTL and testbench
===================================

# change_dispenser

Return-change engine for the soda machine. It accepts a change amount in cents from the vending controller and breaks it down greedily into quarters, dimes and nickels. It issues one coin request at a time to the coin ejector over a valid/ack handshake. It is the consumer side of the credit register path: the controller writes credit in, and this block pays it back out.

## Interface
- WIDTH, 8, bit width of amount and remaining-change datapath (cents)
- QUARTER, 25, quarter value in cents
- DIME, 10, dime value in cents
- NICKEL, 5, nickel value in cents; smallest dispensable unit
- clk  input  1  clock, rising-edge active
- nrst  input  1  reset, asynchronous, active-low
- start  input  1  request to dispense `amount`; sampled only in IDLE
- amount  input  WIDTH  change to return, in cents
- coin_ack  input  1  ejector accepted the presented coin this cycle
- coin_valid  output  1  coin request presented
- coin_sel  output  2  coin type: 2'b11 quarter, 2'b10 dime, 2'b01 nickel, 2'b00 none
- busy  output  1  high in DISPENSE and DONE
- done  output  1  one-cycle pulse at end of a transaction
- error  output  1  residue below NICKEL but nonzero at end; valid with done, held until next start
- remain  output  WIDTH  change not yet dispensed
- coin_count  output  WIDTH  coins accepted in current/last transaction

## Operation
- FSM states: IDLE, DISPENSE, DONE. All state, remain, coin_count and error are registers.
- Reset (nrst low, any time, including mid-handshake):
  - state=IDLE
  - remain=0, coin_count=0, error=0
  - coin_valid=0, coin_sel=0, busy=0, done=0
  - Any in-flight coin request is abandoned with no further pulse.
- IDLE + start=1 at a rising edge:
  - remain<=amount, coin_count<=0, error<=0
  - state<=DISPENSE
- IDLE + start=0: hold all registers.
- DISPENSE: coin_valid and coin_sel are combinational from state and remain (Moore, no input dependence):
  - remain>=QUARTER -> coin_sel=11
  - else remain>=DIME -> coin_sel=10
  - else remain>=NICKEL -> coin_sel=01
  - coin_valid=1 whenever remain>=NICKEL.
- Handshake: a transfer occurs at the rising edge where coin_valid=1 and coin_ack=1.
  - On transfer: remain<=remain - value(coin_sel), coin_count<=coin_count+1.
  - Without ack: coin_valid/coin_sel held stable, no register change.
  - coin_ack while coin_valid=0 is ignored.
- DISPENSE with remain<NICKEL at an edge:
  - state<=DONE
  - error<=(remain!=0)
  - remain is not cleared.
- DONE: done=1 for exactly one cycle, then state<=IDLE.
- start asserted outside IDLE is ignored; amount is not re-sampled.
- Arithmetic: subtraction never underflows, because a coin is only selected when remain>=its value. coin_count wraps modulo 2^WIDTH (unreachable for WIDTH=8 with NICKEL=5).

## Timing
- start sampled at edge E0. DISPENSE begins cycle E0+1; the first coin_valid is visible in that cycle (1-cycle latency).
- With coin_ack tied high: one coin per cycle. A transaction of N coins reaches DONE at edge E0+N+1; done is high in cycle E0+N+2; IDLE from E0+N+3.
- amount=0: DISPENSE for one cycle with coin_valid=0, then done pulse. Total 3 cycles start-to-IDLE, coin_count=0, error=0.
- Back-to-back: start held high is accepted again on the first IDLE cycle after done.
- Ack stalls extend DISPENSE one cycle per stalled cycle; no other effect on timing.

## Test plan
- Reset mid-transfer:
  - Stimulus: amount=40, coin_ack=0; after 3 cycles assert nrst low asynchronously.
  - Response: coin_valid drops immediately; remain=0, busy=0; no done pulse.
- Greedy sequence:
  - Stimulus: amount=40, coin_ack=1.
  - Response: coin_sel 11,10,01 in consecutive cycles; done in 5th cycle after start edge; coin_count=3, remain=0, error=0.
- Ack stall:
  - Stimulus: amount=65, coin_ack low 4 cycles then high.
  - Response: coin_sel=11 held stable for 5 cycles; then 11,10,01 one per cycle; coin_count=4.
- Non-multiple:
  - Stimulus: amount=37, coin_ack=1.
  - Response: 11,10 dispensed, then done with error=1, remain=2, coin_count=2.
- Zero / ignored start:
  - Stimulus: amount=0 → done after 2 cycles, no coin_valid.
  - Stimulus: start pulsed with amount=99 during DISPENSE of amount=15.
  - Response: only 10,01 dispensed; the second request is ignored.
- Max value:
  - Stimulus: amount=255, coin_ack=1.
  - Response: 10 quarters then a nickel; coin_count=11, error=0, done in 13th cycle after start edge.

Source files
------------

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Return-change engine for the soda machine. The vending controller hands
// over a change amount in cents. This block breaks the amount down greedily
// into quarters, dimes and nickels and pays it out one coin at a time to the
// coin ejector over a valid/ack handshake.
//
// Parameters:
//   WIDTH   - width of the amount / remaining-change datapath (cents)
//   QUARTER - quarter value in cents
//   DIME    - dime value in cents
//   NICKEL  - nickel value in cents, the smallest dispensable unit
//
// Ports:
//   clk        - clock, rising-edge active
//   nrst       - asynchronous active-low reset
//   start      - request to dispense `amount`; only looked at while idle
//   amount     - change to return, in cents
//   coin_ack   - ejector accepted the presented coin this cycle
//   coin_valid - a coin request is being presented
//   coin_sel   - coin type: 11 quarter, 10 dime, 01 nickel, 00 none
//   busy       - a transaction is in progress (dispensing or finishing)
//   done       - one-cycle pulse at the end of a transaction
//   error      - a non-zero residue below a nickel was left over; held
//                until the next accepted start
//   remain     - change not yet dispensed
//   coin_count - coins accepted in the current / last transaction
// ---------------------------------------------------------------------------
module change_dispenser #(
   parameter int WIDTH   = 8,
   parameter int QUARTER = 25,
   parameter int DIME    = 10,
   parameter int NICKEL  = 5
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic [WIDTH-1:0] amount,
   input  logic             coin_ack,
   output logic             coin_valid,
   output logic [1:0]       coin_sel,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [WIDTH-1:0] remain,
   output logic [WIDTH-1:0] coin_count
);

   // FSM encoding kept as plain constants so older tooling can read it.
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DISPENSE = 2'd1;
   localparam logic [1:0] ST_DONE     = 2'd2;

   localparam logic [1:0] SEL_NONE    = 2'b00;
   localparam logic [1:0] SEL_NICKEL  = 2'b01;
   localparam logic [1:0] SEL_DIME    = 2'b10;
   localparam logic [1:0] SEL_QUARTER = 2'b11;

   localparam logic [WIDTH-1:0] QUARTER_VAL = WIDTH'(QUARTER);
   localparam logic [WIDTH-1:0] DIME_VAL    = WIDTH'(DIME);
   localparam logic [WIDTH-1:0] NICKEL_VAL  = WIDTH'(NICKEL);

   logic [1:0]       state_q,      state_d;
   logic [WIDTH-1:0] remain_q,     remain_d;
   logic [WIDTH-1:0] coin_count_q, coin_count_d;
   logic             error_q,      error_d;

   logic             in_dispense;
   logic             coin_avail;
   logic [1:0]       sel;
   logic [WIDTH-1:0] sel_value;
   logic             transfer;

   // Coin selection is purely a function of state and remaining change, so
   // the request stays stable while the ejector stalls. A coin is picked
   // only when remain covers its value, which keeps the later subtraction
   // from ever underflowing.
   always_comb begin
      in_dispense = (state_q == ST_DISPENSE);
      coin_avail  = (remain_q >= NICKEL_VAL);
      sel         = SEL_NONE;
      sel_value   = '0;
      if (in_dispense) begin
         if (remain_q >= QUARTER_VAL) begin
            sel       = SEL_QUARTER;
            sel_value = QUARTER_VAL;
         end else if (remain_q >= DIME_VAL) begin
            sel       = SEL_DIME;
            sel_value = DIME_VAL;
         end else if (coin_avail) begin
            sel       = SEL_NICKEL;
            sel_value = NICKEL_VAL;
         end
      end
      transfer = in_dispense && coin_avail && coin_ack;
   end

   // Next-state and datapath update. Registers hold by default; start is
   // only honoured in idle, so a request during a transaction is dropped
   // and amount is not re-sampled.
   always_comb begin
      state_d      = state_q;
      remain_d     = remain_q;
      coin_count_d = coin_count_q;
      error_d      = error_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               remain_d     = amount;
               coin_count_d = '0;
               error_d      = 1'b0;
               state_d      = ST_DISPENSE;
            end
         end
         ST_DISPENSE: begin
            if (coin_avail) begin
               if (transfer) begin
                  remain_d     = remain_q - sel_value;
                  coin_count_d = coin_count_q + WIDTH'(1);
               end
            end else begin
               // Anything left here is a residue no coin can cover; it is
               // reported and left visible on remain.
               error_d = (remain_q != '0);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers. Reset abandons any coin request in flight
   // immediately; no done pulse follows.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         remain_q     <= '0;
         coin_count_q <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         remain_q     <= remain_d;
         coin_count_q <= coin_count_d;
         error_q      <= error_d;
      end
   end

   assign coin_valid = in_dispense && coin_avail;
   assign coin_sel   = sel;
   assign busy       = (state_q == ST_DISPENSE) || (state_q == ST_DONE);
   assign done       = (state_q == ST_DONE);
   assign error      = error_q;
   assign remain     = remain_q;
   assign coin_count = coin_count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
//
// Self-checking bench for change_dispenser. Expected coin sequences are
// pushed to a queue when a transaction is started and popped as the DUT
// hands coins to the (bench-modelled) ejector. A table of transactions is
// run in a loop, followed by hand-written reset and back-to-back sequences.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

   logic       clk;
   logic       nrst;
   logic       start;
   logic [7:0] amount;
   logic       coin_ack;
   logic       coin_valid;
   logic [1:0] coin_sel;
   logic       busy;
   logic       done;
   logic       error;
   logic [7:0] remain;
   logic [7:0] coin_count;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_q[$];

   typedef struct {
      logic [7:0] amount;
      int         stalls;
      bit         poke;
      int         exp_count;
      int         exp_remain;
      bit         exp_error;
      int         done_cycle;
   } vec_t;

   vec_t vecs[8];

   change_dispenser #(
      .WIDTH(8), .QUARTER(25), .DIME(10), .NICKEL(5)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start),
      .amount     (amount),
      .coin_ack   (coin_ack),
      .coin_valid (coin_valid),
      .coin_sel   (coin_sel),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .remain     (remain),
      .coin_count (coin_count)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded loops.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int coin_value(input logic [1:0] sel);
      case (sel)
         2'b11:   return 25;
         2'b10:   return 10;
         2'b01:   return 5;
         default: return 0;
      endcase
   endfunction

   // Drive a start request and push the greedy coin sequence for it.
   task automatic apply_stimulus(input logic [7:0] amt);
      int r;
      @(negedge clk);
      start  = 1'b1;
      amount = amt;
      r = int'(amt);
      while (r >= 25) begin exp_q.push_back(2'b11); r -= 25; end
      while (r >= 10) begin exp_q.push_back(2'b10); r -= 10; end
      while (r >= 5)  begin exp_q.push_back(2'b01); r -= 5;  end
      @(posedge clk);
   endtask

   task automatic run_vector(input vec_t v);
      int  model_rem;
      bit  seen_done;
      apply_stimulus(v.amount);
      model_rem = int'(v.amount);
      seen_done = 1'b0;
      for (int k = 1; k <= 40 && !seen_done; k++) begin
         @(negedge clk);
         start    = v.poke && (k <= 2);
         amount   = (v.poke && (k <= 2)) ? 8'd99 : 8'd0;
         coin_ack = (k > v.stalls);
         #1;
         check_output("busy_during_txn", busy, 1);
         if (done) begin
            seen_done = 1'b1;
            check_output("done_cycle", k, v.done_cycle);
            check_output("coin_count", coin_count, v.exp_count);
            check_output("remain_end", remain, v.exp_remain);
            check_output("error_end", error, v.exp_error);
            check_output("coins_left", exp_q.size(), 0);
         end else begin
            check_output("remain", remain, model_rem);
            check_output("coin_valid", coin_valid, model_rem >= 5);
            if (coin_valid && exp_q.size() > 0) begin
               check_output("coin_sel", coin_sel, exp_q[0]);
               if (coin_ack) begin
                  model_rem -= coin_value(exp_q[0]);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
      if (!seen_done)
         check_output("done_timeout", 0, 1);
      exp_q.delete();
      @(negedge clk);
      start    = 1'b0;
      coin_ack = 1'b0;
      #1;
      check_output("idle_busy", busy, 0);
      check_output("idle_done", done, 0);
      check_output("idle_error_held", error, v.exp_error);
      check_output("idle_count_held", coin_count, v.exp_count);
   endtask

   initial begin
      vecs[0] = '{8'd40,  0, 1'b0, 3,  0, 1'b0, 5};
      vecs[1] = '{8'd65,  4, 1'b0, 4,  0, 1'b0, 10};
      vecs[2] = '{8'd37,  0, 1'b0, 2,  2, 1'b1, 4};
      vecs[3] = '{8'd0,   0, 1'b0, 0,  0, 1'b0, 2};
      vecs[4] = '{8'd15,  0, 1'b1, 2,  0, 1'b0, 4};
      vecs[5] = '{8'd255, 0, 1'b0, 11, 0, 1'b0, 13};
      vecs[6] = '{8'd4,   0, 1'b0, 0,  4, 1'b1, 2};
      vecs[7] = '{8'd30,  2, 1'b0, 2,  0, 1'b0, 6};

      nrst     = 1'b0;
      start    = 1'b0;
      amount   = 8'd0;
      coin_ack = 1'b0;
      #1;
      check_output("rst_coin_valid", coin_valid, 0);
      check_output("rst_coin_sel", coin_sel, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_error", error, 0);
      check_output("rst_remain", remain, 0);
      check_output("rst_count", coin_count, 0);
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;

      // Reset mid-transfer: ejector never acks, reset lands between edges.
      @(negedge clk);
      start    = 1'b1;
      amount   = 8'd40;
      coin_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_output("pre_rst_valid", coin_valid, 1);
      check_output("pre_rst_sel", coin_sel, 3);
      #2;
      nrst = 1'b0;
      #1;
      check_output("midrst_valid", coin_valid, 0);
      check_output("midrst_remain", remain, 0);
      check_output("midrst_busy", busy, 0);
      check_output("midrst_count", coin_count, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         check_output("midrst_no_done", done, 0);
      end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      #1;
      check_output("post_rst_busy", busy, 0);
      check_output("post_rst_done", done, 0);

      for (int i = 0; i < 8; i++)
         run_vector(vecs[i]);

      // Back-to-back: start held high is taken again on the first idle cycle.
      @(negedge clk);
      start    = 1'b1;
      amount   = 8'd10;
      coin_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_output("b2b_sel", coin_sel, 2);
      @(negedge clk);
      @(negedge clk);
      #1;
      check_output("b2b_done", done, 1);
      @(negedge clk);
      #1;
      check_output("b2b_idle_gap", busy, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check_output("b2b_restart_busy", busy, 1);
      check_output("b2b_restart_remain", remain, 10);
      begin
         bit got_done;
         got_done = 1'b0;
         for (int k = 0; k < 10 && !got_done; k++) begin
            @(negedge clk);
            #1;
            if (done) got_done = 1'b1;
         end
         check_output("b2b_second_done", got_done, 1);
         check_output("b2b_second_count", coin_count, 1);
      end
      @(negedge clk);
      coin_ack = 1'b0;
      #1;
      check_output("b2b_final_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
